// File: rtl/rx_pkt_buf_if.sv
// rx_pkt_buf_if
// Groups the sample input, stream output and status signals of the receive packet
// buffer into one bundle.
//   master : the sample source / stream sink side. It drives i_en, i_data_i,
//            i_data_q, i_vld, i_sop and i_tready. It observes o_tdata, o_tvalid,
//            o_tlast, o_busy, o_drop_cnt and o_pkt_cnt.
//   slave  : the rx_pkt_buf side, with the opposite directions.
// DW is the width of one I or Q component. A stream word is {q,i}, 2*DW bits.
interface rx_pkt_buf_if #(
    parameter int DW = 16
);
    logic                 i_en;
    logic signed [DW-1:0] i_data_i;
    logic signed [DW-1:0] i_data_q;
    logic                 i_vld;
    logic                 i_sop;
    logic [2*DW-1:0]      o_tdata;
    logic                 o_tvalid;
    logic                 o_tlast;
    logic                 i_tready;
    logic                 o_busy;
    logic [7:0]           o_drop_cnt;
    logic [15:0]          o_pkt_cnt;

    modport master (
        output i_en, i_data_i, i_data_q, i_vld, i_sop, i_tready,
        input  o_tdata, o_tvalid, o_tlast, o_busy, o_drop_cnt, o_pkt_cnt
    );

    modport slave (
        input  i_en, i_data_i, i_data_q, i_vld, i_sop, i_tready,
        output o_tdata, o_tvalid, o_tlast, o_busy, o_drop_cnt, o_pkt_cnt
    );
endinterface

// File: rtl/rx_pkt_buf.sv
// rx_pkt_buf
// Captures one packet of PKT_LEN complex samples after a start-of-packet pulse.
// It then replays the packet as an AXI-Stream burst toward the DMA. The block holds
// a single packet. Any SOP that arrives while the block is busy is dropped and
// counted in a saturating counter.
// Ports:
//   i_clk  : system clock.
//   i_rst  : synchronous, active-high reset.
//   bus    : rx_pkt_buf_if.slave. It carries the following signals.
//            - Arm enable and SOP: i_en, i_sop.
//            - Samples: i_data_i, i_data_q, i_vld.
//            - Stream: o_tdata, o_tvalid, o_tlast, i_tready.
//            - Status: o_busy, o_drop_cnt, o_pkt_cnt.
module rx_pkt_buf #(
    parameter int PKT_LEN = 256,
    parameter int DW      = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rx_pkt_buf_if.slave  bus
);
    localparam int            AW        = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t state, state_next;

    logic [2*DW-1:0] mem [PKT_LEN];
    logic [2*DW-1:0] ram_q;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_addr;
    logic            wr_en;
    logic            arm;

    logic [AW-1:0]   rd_ptr;
    logic            rd_done;
    logic            rd_issue;
    logic            rd_pend;
    logic            rd_pend_last;

    logic            skid_vld;
    logic            skid_last;
    logic [2*DW-1:0] skid_data;

    logic            tvalid_q;
    logic            tlast_q;
    logic [2*DW-1:0] tdata_q;
    logic            busy_q;
    logic [7:0]      drop_cnt_q;
    logic [15:0]     pkt_cnt_q;

    logic            pop;
    logic            last_pop;
    logic [1:0]      occ_next;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode.
    // occ_next is the number of beats that the output register, the skid register
    // and an arriving RAM read will hold after this cycle. A new read is issued only
    // when that count leaves room for the read to land next cycle, so no beat is
    // ever lost under backpressure.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr;
        arm        = 1'b0;
        rd_issue   = 1'b0;
        pop        = tvalid_q && bus.i_tready;
        last_pop   = pop && tlast_q;
        occ_next   = 2'(tvalid_q) + 2'(skid_vld) + 2'(rd_pend) - 2'(pop);
        case (state)
            ST_IDLE: begin
                if (bus.i_sop && bus.i_en) begin
                    arm        = 1'b1;
                    state_next = ST_CAPTURE;
                    if (bus.i_vld) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                    end
                end
            end
            ST_CAPTURE: begin
                if (bus.i_vld) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                rd_issue = !rd_done && (occ_next <= 2'd1);
                if (last_pop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Packet RAM: one write port and one registered read port. It has no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {bus.i_data_q, bus.i_data_i};
        end
        if (rd_issue) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Pointers, read pipeline, output/skid registers and counters.
    // Read data arriving from the RAM goes to the output register when it is free,
    // or into the skid register when the sink stalls. The skid register is always
    // older than any arriving read, so it is drained first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_done      <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            skid_vld     <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE:    wr_ptr <= (arm && bus.i_vld) ? AW'(1) : '0;
                ST_CAPTURE: begin
                    if (bus.i_vld) begin
                        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
                    end
                end
                default:    wr_ptr <= '0;
            endcase

            if (state != ST_DRAIN) begin
                rd_ptr   <= '0;
                rd_done  <= 1'b0;
                rd_pend  <= 1'b0;
                skid_vld <= 1'b0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                rd_pend <= rd_issue;
                if (rd_issue) begin
                    rd_pend_last <= (rd_ptr == LAST_ADDR);
                    if (rd_ptr == LAST_ADDR) begin
                        rd_done <= 1'b1;
                        rd_ptr  <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end

                if (!tvalid_q || pop) begin
                    if (skid_vld) begin
                        tvalid_q  <= 1'b1;
                        tdata_q   <= skid_data;
                        tlast_q   <= skid_last;
                        skid_vld  <= rd_pend;
                        skid_data <= ram_q;
                        skid_last <= rd_pend_last;
                    end else if (rd_pend) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= ram_q;
                        tlast_q  <= rd_pend_last;
                    end else begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end else if (rd_pend) begin
                    skid_vld  <= 1'b1;
                    skid_data <= ram_q;
                    skid_last <= rd_pend_last;
                end
            end

            busy_q <= (state_next != ST_IDLE);

            if (bus.i_sop && (state != ST_IDLE) && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            if (last_pop) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_tdata    = tdata_q;
    assign bus.o_tvalid   = tvalid_q;
    assign bus.o_tlast    = tlast_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_drop_cnt = drop_cnt_q;
    assign bus.o_pkt_cnt  = pkt_cnt_q;
endmodule
